cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 32 +++
 rtl/cpu_seq_decode.sv | 11 +
 rtl/cpu_sequencer.sv | 117 +++++++++++
 tb/tb_cpu_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared state/class enums, opcode constants and the opcode-to-class helper
// used by the CPU sequencer and by any datapath that needs the same decode.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_PC     = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_LOAD    = 2'd1,
    CLS_STORE   = 2'd2,
    CLS_ILLEGAL = 2'd3
  } iclass_e;

  localparam logic [5:0] OPC_LOAD    = 6'b011000;
  localparam logic [5:0] OPC_STORE   = 6'b011001;
  localparam int         OPC_ALU_BIT = 5;

  function automatic iclass_e decode_opcode(input logic [5:0] opcode);
    if (opcode[OPC_ALU_BIT])       return CLS_ALU;
    else if (opcode == OPC_LOAD)   return CLS_LOAD;
    else if (opcode == OPC_STORE)  return CLS_STORE;
    else                           return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational opcode-to-instruction-class decode.
module cpu_seq_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  output iclass_e    iclass
);

  assign iclass = decode_opcode(opcode);

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: FETCH -> PC -> DECODE -> EXEC handshake with sub-FSMs.
// Define CPU_SEQUENCER_WATCHDOG_EN to compile in the per-phase watchdog and HALT.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_contr,
  input  logic [WIDTH-1:0] instr,
  input  logic             fetch_done,
  input  logic             pc_done,
  input  logic             exec_done,
  output logic             go_fetch,
  output logic             go_pc,
  output logic             go_alu,
  output logic             go_load,
  output logic             go_store,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic             timeout
);

  state_e  state, state_next;
  iclass_e cls_dec, cls_reg;
  logic    phase_expired;
  logic    unused_instr;

  // Only the opcode field steers the sequencer; the rest belongs to the datapath.
  assign unused_instr = ^instr;

  cpu_seq_decode u_decode (
    .opcode (instr[31:26]),
    .iclass (cls_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

`ifdef CPU_SEQUENCER_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic [WD_W-1:0] wdog_cnt;

  // Restarts on every state entry, so each handshake phase gets its own budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wdog_cnt <= '0;
    else if (state_next != state)
      wdog_cnt <= '0;
    else if (state == S_FETCH || state == S_PC || state == S_EXEC)
      wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign phase_expired = (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
  assign timeout       = (state == S_HALT);
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign phase_expired = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (go_contr) state_next = S_FETCH;
      S_FETCH:  if (fetch_done) state_next = S_PC;
                else if (phase_expired) state_next = S_HALT;
      S_PC:     if (pc_done) state_next = S_DECODE;
                else if (phase_expired) state_next = S_HALT;
      S_DECODE: if (cls_dec == CLS_ILLEGAL) state_next = go_contr ? S_FETCH : S_IDLE;
                else state_next = S_EXEC;
      S_EXEC:   if (exec_done) state_next = go_contr ? S_FETCH : S_IDLE;
                else if (phase_expired) state_next = S_HALT;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  // Class is held for the whole EXEC phase even if instr changes underneath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_reg <= CLS_ILLEGAL;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (state == S_DECODE) cls_reg <= cls_dec;
      illegal <= (state == S_DECODE) && (cls_dec == CLS_ILLEGAL);
      if (state == S_EXEC && exec_done) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    go_fetch = 1'b0;
    go_pc    = 1'b0;
    go_alu   = 1'b0;
    go_load  = 1'b0;
    go_store = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_FETCH: go_fetch = 1'b1;
      S_PC:    go_pc    = 1'b1;
      S_EXEC: begin
        go_alu   = (cls_reg == CLS_ALU);
        go_load  = (cls_reg == CLS_LOAD);
        go_store = (cls_reg == CLS_STORE);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: phase-level expected trace per program, reactive done
// responders, plus hand-computed literal checks on retired/illegal/reset/watchdog.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go_contr = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        fetch_done = 1'b0, pc_done = 1'b0, exec_done = 1'b0;
  logic        go_fetch, go_pc, go_alu, go_load, go_store, busy, illegal, timeout;
  logic [15:0] retired;

  always #5 clk = ~clk;

  cpu_sequencer #(.WIDTH(32), .CNT_W(16), .WDOG_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .go_contr(go_contr), .instr(instr),
    .fetch_done(fetch_done), .pc_done(pc_done), .exec_done(exec_done),
    .go_fetch(go_fetch), .go_pc(go_pc), .go_alu(go_alu), .go_load(go_load),
    .go_store(go_store), .busy(busy), .illegal(illegal), .retired(retired),
    .timeout(timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
  endtask

  // One observation per cycle: go_fetch, go_pc, go_alu, go_load, go_store, busy, illegal, retired.
  typedef struct packed {
    logic        f, p, a, l, s, b, il;
    logic [15:0] ret;
  } obs_t;

  obs_t        exp_q[$];
  logic [31:0] prog[$];
  int          ret_m    = 0;
  bit          ill_pend = 1'b0;

  function automatic void push(input logic f, p, a, l, s, b);
    obs_t e;
    e.f = f; e.p = p; e.a = a; e.l = l; e.s = s; e.b = b;
    e.il = ill_pend;
    ill_pend = 1'b0;
    e.ret = 16'(ret_m);
    exp_q.push_back(e);
  endfunction

  // Every phase lasts lat+1 cycles, DECODE one; an illegal op shows up on the cycle after DECODE.
  function automatic void model_run(input int lat);
    logic [5:0] opc;
    foreach (prog[i]) begin
      opc = prog[i][31:26];
      repeat (lat + 1) push(1, 0, 0, 0, 0, 1);
      repeat (lat + 1) push(0, 1, 0, 0, 0, 1);
      push(0, 0, 0, 0, 0, 1);
      if (opc[5]) begin
        repeat (lat + 1) push(0, 0, 1, 0, 0, 1);
        ret_m = (ret_m + 1) % 65536;
      end else if (opc == 6'b011000) begin
        repeat (lat + 1) push(0, 0, 0, 1, 0, 1);
        ret_m = (ret_m + 1) % 65536;
      end else if (opc == 6'b011001) begin
        repeat (lat + 1) push(0, 0, 0, 0, 1, 1);
        ret_m = (ret_m + 1) % 65536;
      end else begin
        ill_pend = 1'b1;
      end
    end
    repeat (3) push(0, 0, 0, 0, 0, 0);
  endfunction

  bit checking  = 1'b0;
  bit withhold  = 1'b0;
  bit noise     = 1'b0;
  int lat       = 0;
  int drop_mode = 0;
  int pidx      = 0;
  int fcnt = 0, pcnt = 0, ecnt = 0;
  int n_ill = 0;

  // Compare against the trace, then play the fetch/PC/execute sub-FSMs.
  always @(negedge clk) begin
    obs_t got, want;
    got = {go_fetch, go_pc, go_alu, go_load, go_store, busy, illegal, retired};
    if (checking && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check("trace", 32'(got), 32'(want));
    end
    if (illegal) n_ill++;
    fcnt = go_fetch ? fcnt + 1 : 0;
    pcnt = go_pc ? pcnt + 1 : 0;
    ecnt = (go_alu | go_load | go_store) ? ecnt + 1 : 0;
    fetch_done = go_fetch ? (!withhold && fcnt > lat) : noise;
    pc_done    = go_pc ? (pcnt > lat) : noise;
    exec_done  = (go_alu | go_load | go_store) ? (ecnt > lat) : noise;
    if (go_fetch && fetch_done) begin
      instr = (pidx < prog.size()) ? prog[pidx] : 32'h0;
      pidx++;
      if (drop_mode == 0 && pidx >= prog.size()) go_contr = 1'b0;
    end
    if (drop_mode == 1 && (go_alu | go_load | go_store) && pidx >= prog.size())
      go_contr = 1'b0;
  end

  task automatic do_reset();
    reset = 1'b1; go_contr = 1'b0; withhold = 1'b0; noise = 1'b0;
    ret_m = 0; ill_pend = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_prog(input int l, input int dmode, input bit nz);
    lat = l; drop_mode = dmode; noise = nz; pidx = 0;
    model_run(l);
    @(negedge clk); #1;
    go_contr = 1'b1; reset = 1'b0; checking = 1'b1;
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      @(negedge clk); #2;
    end
    check("trace_drained", exp_q.size(), 0);
    exp_q.delete();
    checking = 1'b0; noise = 1'b0;
  endtask

  initial begin
    int hi;
    #2;
    check("reset_flags", {go_fetch, go_pc, go_alu, go_load, go_store, busy, illegal, timeout}, 0);
    check("reset_retired", retired, 0);

    // Single ALU op straight out of reset, dones one cycle after each go.
    prog = '{32'h8000_0800};
    go_contr = 1'b1;
    run_prog(1, 0, 1'b0);
    check("A_retired", retired, 1);
    $display("txn A: ADD lat=1 retired=%0d", retired);

    // ADD, LOAD, STORE back to back with immediate dones.
    do_reset();
    prog = '{32'h8000_0800, 32'h6080_0000, 32'h6400_0000};
    run_prog(0, 0, 1'b0);
    check("B_retired", retired, 3);
    $display("txn B: ADD/LOAD/STORE lat=0 retired=%0d", retired);

    // 0xFC000000 has opcode[5] set, so it decodes as ALU; opcode 000011 is the illegal one.
    do_reset();
    n_ill = 0;
    prog = '{32'h0C00_0000, 32'hFC00_0000};
    run_prog(1, 0, 1'b0);
    check("C_illegal_pulses", n_ill, 1);
    check("C_retired", retired, 1);
    $display("txn C: illegal+ALU illegal_pulses=%0d retired=%0d", n_ill, retired);

    // go_contr dropped in EXEC with stray dones outside their phases.
    prog = '{32'h6080_0000};
    run_prog(2, 1, 1'b1);
    check("D_retired", retired, 2);
    check("D_idle", {busy, go_fetch}, 0);
    $display("txn D: LOAD drop-in-EXEC retired=%0d busy=%0b", retired, busy);

    // Asynchronous reset in the middle of a LOAD execute phase.
    lat = 3; drop_mode = 0; noise = 1'b0; pidx = 0;
    prog = '{32'h6080_0000};
    @(negedge clk); #1 go_contr = 1'b1;
    for (int c = 0; c < 100 && !go_load; c++) begin
      @(posedge clk); #2;
    end
    check("E_go_load_before", go_load, 1);
    check("E_retired_before", retired, 2);
    reset = 1'b1;
    #1;
    check("E_go_load_async", go_load, 0);
    check("E_busy_async", busy, 0);
    check("E_retired_async", retired, 0);
    $display("txn E: async reset mid-EXEC go_load=%0b busy=%0b retired=%0d", go_load, busy, retired);

    // fetch_done withheld forever.
    do_reset();
    withhold = 1'b1; go_contr = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    hi = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #2;
      if (go_fetch) hi++;
    end
`ifdef CPU_SEQUENCER_WATCHDOG_EN
    check("F_fetch_cycles", hi, 64);
    check("F_timeout", timeout, 1);
    check("F_halt_outputs", {go_fetch, go_pc, go_alu, go_load, go_store, busy}, 6'b000001);
    reset = 1'b1;
    #1;
    check("F_timeout_cleared", timeout, 0);
`else
    check("F_fetch_cycles", hi, 200);
    check("F_timeout", timeout, 0);
    check("F_still_fetching", {go_fetch, busy}, 2'b11);
`endif
    $display("txn F: withheld fetch go_fetch_cycles=%0d timeout=%0b", hi, timeout);

    reset = 1'b1; withhold = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
